alu_datapath: RTL

Operand/result datapath of the 8-bit ALU, the execution side of the control-unit interface. It takes the 11-bit control word `c` and executes register loads, add/subtract, shifts and counting. It returns the status bits the control unit branches on: `q0`, `q_1`, `a_8` and `cnt`. It executes add/sub/Booth-multiply/divide sequences exactly as commanded and has no sequencing of its own.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_adder9.sv | 18 +
 rtl/alu_datapath.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, control-word bit indices and op-select encoding
package alu_pkg;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W);

  localparam int C_LD_M    = 0;
  localparam int C_LD_Q    = 1;
  localparam int C_ADD     = 2;
  localparam int C_SUB     = 3;
  localparam int C_RSH     = 4;
  localparam int C_LSH     = 5;
  localparam int C_SETQ0   = 6;
  localparam int C_CNT_INC = 7;
  localparam int C_OUT_A   = 8;
  localparam int C_OUT_Q   = 9;
  localparam int C_LD_A    = 10;
  localparam int C_WIDTH   = 11;

  // Operation select driven by the control unit's s input.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_adder9.sv
// rtl/alu_adder9.sv - A +/- M adder; subtraction as invert plus carry-in
module alu_adder9 #(
  parameter int WA = 9
) (
  input  logic [WA-1:0] a_i,
  input  logic [WA-1:0] b_i,
  input  logic          sub_i,
  output logic [WA-1:0] sum_o
);

  logic [WA-1:0] b_eff;
  logic [WA-1:0] cin;

  assign b_eff = b_i ^ {WA{sub_i}};
  assign cin   = {{(WA-1){1'b0}}, sub_i};
  assign sum_o = a_i + b_eff + cin;

endmodule

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - A/Q/M operand datapath executing one control word per cycle
module alu_datapath
  import alu_pkg::*;
#(
  parameter int W = alu_pkg::W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [C_WIDTH-1:0]    c,
  input  logic [W-1:0]          inbus,
  output logic [W-1:0]          outbus,
  output logic                  out_valid,
  output logic                  q0,
  output logic                  q_1,
  output logic                  a_8,
  output logic [$clog2(W)-1:0]  cnt
);

  localparam int CW = $clog2(W);

  logic [W:0]    a_q, a_d, m_q, m_d, sum;
  logic [W-1:0]  q_q, q_d, out_q, out_d;
  logic          q1_q, q1_d, ov_q, ov_d;
  logic [CW-1:0] cnt_q, cnt_d;

  alu_adder9 #(.WA(W + 1)) u_adder (
    .a_i   (a_q),
    .b_i   (m_q),
    .sub_i (c[C_SUB]),
    .sum_o (sum)
  );

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    q1_d  = q1_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    out_d = out_q;
    ov_d  = c[C_OUT_A] | c[C_OUT_Q];

    if (c[C_LD_M]) m_d = {inbus[W-1], inbus};
    // Arithmetic result feeds a same-cycle shift (Booth/divide step).
    if (c[C_ADD] | c[C_SUB]) a_d = sum;
    if (c[C_RSH] & ~c[C_LSH]) {a_d, q_d, q1_d} = {a_d[W], a_d, q_d};
    if (c[C_LSH] & ~c[C_RSH]) {a_d, q_d} = {a_d[W-1:0], q_d, 1'b0};
    if (c[C_SETQ0]) q_d[0] = 1'b1;

    if (c[C_LD_Q]) begin
      a_d  = '0;
      q_d  = inbus;
      q1_d = 1'b0;
    end else if (c[C_LD_A]) begin
      a_d = {inbus[W-1], inbus};
    end

    if (c[C_LD_Q])         cnt_d = '0;
    else if (c[C_CNT_INC]) cnt_d = cnt_q + CW'(1);

    if (c[C_OUT_Q])        out_d = q_q;
    else if (c[C_OUT_A])   out_d = a_q[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ov_q  <= ov_d;
    end
  end

  assign outbus    = out_q;
  assign out_valid = ov_q;
  assign q0        = q_q[0];
  assign q_1       = q1_q;
  assign a_8       = a_q[W];
  assign cnt       = cnt_q;

endmodule
